window_gen_5x5: RTL and testbench

Streaming 5x5 neighbourhood generator that feeds the pipelined median sorter. It accepts a raster-order 8-bit pixel stream, buffers four image lines and emits the full 25-tap window (x_0..x_24) with a valid strobe each time an accepted pixel completes a window. It sits directly upstream of sort_pipe: window taps connect 1:1 to the sorter's x_0..x_24 inputs.

---
 rtl/window_gen_5x5.sv | 161 ++++++++++++++++
 tb/tb_window_gen_5x5.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 neighbourhood generator: four line buffers plus a 25-tap shift window,
// emitting a window strobe whenever an accepted raster pixel completes a full neighbourhood.
module window_gen_5x5 #(
  parameter int DW    = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic [DW-1:0]            x_0,
  output logic [DW-1:0]            x_1,
  output logic [DW-1:0]            x_2,
  output logic [DW-1:0]            x_3,
  output logic [DW-1:0]            x_4,
  output logic [DW-1:0]            x_5,
  output logic [DW-1:0]            x_6,
  output logic [DW-1:0]            x_7,
  output logic [DW-1:0]            x_8,
  output logic [DW-1:0]            x_9,
  output logic [DW-1:0]            x_10,
  output logic [DW-1:0]            x_11,
  output logic [DW-1:0]            x_12,
  output logic [DW-1:0]            x_13,
  output logic [DW-1:0]            x_14,
  output logic [DW-1:0]            x_15,
  output logic [DW-1:0]            x_16,
  output logic [DW-1:0]            x_17,
  output logic [DW-1:0]            x_18,
  output logic [DW-1:0]            x_19,
  output logic [DW-1:0]            x_20,
  output logic [DW-1:0]            x_21,
  output logic [DW-1:0]            x_22,
  output logic [DW-1:0]            x_23,
  output logic [DW-1:0]            x_24,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] win_q [25];
  logic [DW-1:0] win_d [25];
  logic [DW-1:0] lb_q [4][IMG_W];
  logic [DW-1:0] lb_d [4][IMG_W];
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          frame_done_q, frame_done_d;

  logic [CW-1:0] cur_c;
  logic [RW-1:0] cur_r;
  logic [DW-1:0] vec [5];

  // sof forces the accepted pixel to (0,0); row gating keeps stale lines from ever validating a window
  always_comb begin
    cur_c        = sof ? '0 : col_q;
    cur_r        = sof ? '0 : row_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    lb_d         = lb_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    for (int r = 0; r < 4; r++) vec[r] = lb_q[r][cur_c];
    vec[4] = pix_in;

    if (pix_valid) begin
      for (int r = 0; r < 4; r++) lb_d[r][cur_c] = vec[r+1];
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win_d[5*r+c] = win_q[5*r+c+1];
        win_d[5*r+4] = vec[r];
      end

      if (cur_r >= RW'(4) && cur_c >= CW'(4)) begin
        win_valid_d = 1'b1;
        win_row_d   = cur_r - RW'(2);
        win_col_d   = cur_c - CW'(2);
      end

      if (cur_c == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (cur_r == RW'(IMG_H - 1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = cur_r + RW'(1);
        end
      end else begin
        col_d = cur_c + CW'(1);
        row_d = cur_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line storage is deliberately left unreset; its contents are only exposed after being refilled
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

  assign x_0  = win_q[0];
  assign x_1  = win_q[1];
  assign x_2  = win_q[2];
  assign x_3  = win_q[3];
  assign x_4  = win_q[4];
  assign x_5  = win_q[5];
  assign x_6  = win_q[6];
  assign x_7  = win_q[7];
  assign x_8  = win_q[8];
  assign x_9  = win_q[9];
  assign x_10 = win_q[10];
  assign x_11 = win_q[11];
  assign x_12 = win_q[12];
  assign x_13 = win_q[13];
  assign x_14 = win_q[14];
  assign x_15 = win_q[15];
  assign x_16 = win_q[16];
  assign x_17 = win_q[17];
  assign x_18 = win_q[18];
  assign x_19 = win_q[19];
  assign x_20 = win_q[20];
  assign x_21 = win_q[21];
  assign x_22 = win_q[22];
  assign x_23 = win_q[23];
  assign x_24 = win_q[24];

  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_5x5.sv
// Bench for window_gen_5x5 on an 8x8 image: an image-array reference model checks every cycle,
// and a small table of hand-computed ramp windows pins down the first, middle and last strobes.
module tb_window_gen_5x5;

  localparam int W = 8;
  localparam int H = 8;

  typedef struct {
    logic [7:0] x0, x4, x12, x24;
    int         row, col;
    bit         fd;
  } strobe_t;

  typedef struct {
    int         idx;
    logic [7:0] x0, x4, x12, x24;
    int         row, col;
    bit         fd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8, x_9, x_10, x_11, x_12;
  logic [7:0] x_13, x_14, x_15, x_16, x_17, x_18, x_19, x_20, x_21, x_22, x_23, x_24;
  logic       win_valid, frame_done;
  logic [2:0] win_row, win_col;
  logic [7:0] dut_win [25];

  int         n_checks = 0;
  int         n_errors = 0;

  logic [7:0] img [H][W];
  int         m_r, m_c;
  logic [7:0] exp_win [25];
  bit         exp_known, exp_valid, exp_fd;
  int         exp_row, exp_col;
  strobe_t    strobes [$];
  int         fd_count;
  logic [7:0] sent [W*H];
  vec_t       vecs [4];

  window_gen_5x5 #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3), .x_4(x_4), .x_5(x_5), .x_6(x_6),
    .x_7(x_7), .x_8(x_8), .x_9(x_9), .x_10(x_10), .x_11(x_11), .x_12(x_12),
    .x_13(x_13), .x_14(x_14), .x_15(x_15), .x_16(x_16), .x_17(x_17), .x_18(x_18),
    .x_19(x_19), .x_20(x_20), .x_21(x_21), .x_22(x_22), .x_23(x_23), .x_24(x_24),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  assign dut_win = '{x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8, x_9, x_10, x_11, x_12,
                     x_13, x_14, x_15, x_16, x_17, x_18, x_19, x_20, x_21, x_22, x_23, x_24};

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_r = 0;
    m_c = 0;
    for (int i = 0; i < 25; i++) exp_win[i] = '0;
    exp_known = 1'b1;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    exp_row   = 0;
    exp_col   = 0;
  endtask

  // Reference: store the frame as a 2-D image and read each window straight out of it
  task automatic model_accept(input logic [7:0] p, input bit s);
    int lin;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (s) begin
      m_r = 0;
      m_c = 0;
    end
    img[m_r][m_c] = p;
    if (m_r >= 4 && m_c >= 4) begin
      exp_valid = 1'b1;
      exp_known = 1'b1;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) exp_win[5*r+c] = img[m_r-4+r][m_c-4+c];
      exp_row = m_r - 2;
      exp_col = m_c - 2;
    end else begin
      exp_known = 1'b0;
    end
    if (m_r == H - 1 && m_c == W - 1) exp_fd = 1'b1;
    lin = (m_r * W + m_c + 1) % (W * H);
    m_r = lin / W;
    m_c = lin % W;
  endtask

  task automatic checkOutput();
    logic [255:0] act_w, req_w;
    compare("win_valid", 256'(win_valid), 256'(exp_valid));
    compare("frame_done", 256'(frame_done), 256'(exp_fd));
    compare("win_row", 256'(win_row), 256'(exp_row));
    compare("win_col", 256'(win_col), 256'(exp_col));
    if (exp_known) begin
      act_w = '0;
      req_w = '0;
      for (int i = 0; i < 25; i++) begin
        act_w[8*i +: 8] = dut_win[i];
        req_w[8*i +: 8] = exp_win[i];
      end
      compare("taps", act_w, req_w);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] p, input bit s);
    strobe_t st;
    pix_valid = v;
    pix_in    = v ? p : 8'($urandom);
    sof       = v ? s : 1'($urandom);
    if (v) model_accept(p, s);
    else begin
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput();
    if (win_valid) begin
      st.x0 = x_0; st.x4 = x_4; st.x12 = x_12; st.x24 = x_24;
      st.row = int'(win_row); st.col = int'(win_col); st.fd = frame_done;
      strobes.push_back(st);
    end
    if (frame_done) fd_count++;
  endtask

  task automatic send_frame(input int base, input bit use_sof, input int idle_max,
                            input int n_pix, input bit rnd);
    logic [7:0] p;
    int idle;
    for (int i = 0; i < n_pix; i++) begin
      idle = (idle_max > 0) ? int'($urandom_range(idle_max, 0)) : 0;
      for (int k = 0; k < idle; k++) applyStimulus(1'b0, 8'h00, 1'b0);
      p = rnd ? 8'($urandom) : 8'(base + i);
      sent[i] = p;
      applyStimulus(1'b1, p, use_sof && i == 0);
    end
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n     = 1'b0;
    pix_valid = 1'($urandom);
    pix_in    = 8'($urandom);
    sof       = 1'($urandom);
    #2;
    model_reset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    pix_valid = 1'b0;
    sof       = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic start_capture();
    strobes.delete();
    fd_count = 0;
  endtask

  task automatic check_ramp_table(input string tag);
    compare({tag, "_strobes"}, 256'(strobes.size()), 256'(16));
    compare({tag, "_frame_done"}, 256'(fd_count), 256'(1));
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].idx < strobes.size()) begin
        compare({tag, "_x0"}, 256'(strobes[vecs[i].idx].x0), 256'(vecs[i].x0));
        compare({tag, "_x4"}, 256'(strobes[vecs[i].idx].x4), 256'(vecs[i].x4));
        compare({tag, "_x12"}, 256'(strobes[vecs[i].idx].x12), 256'(vecs[i].x12));
        compare({tag, "_x24"}, 256'(strobes[vecs[i].idx].x24), 256'(vecs[i].x24));
        compare({tag, "_row"}, 256'(strobes[vecs[i].idx].row), 256'(vecs[i].row));
        compare({tag, "_col"}, 256'(strobes[vecs[i].idx].col), 256'(vecs[i].col));
        compare({tag, "_fd"}, 256'(strobes[vecs[i].idx].fd), 256'(vecs[i].fd));
      end else begin
        compare({tag, "_strobe_missing"}, 256'(strobes.size()), 256'(vecs[i].idx + 1));
      end
    end
  endtask

  initial begin
    // Hand-computed windows of the 8x8 ramp pix = 8*row + col
    vecs[0] = '{idx: 0,  x0: 8'd0,  x4: 8'd4,  x12: 8'd18, x24: 8'd36, row: 2, col: 2, fd: 1'b0};
    vecs[1] = '{idx: 5,  x0: 8'd9,  x4: 8'd13, x12: 8'd27, x24: 8'd45, row: 3, col: 3, fd: 1'b0};
    vecs[2] = '{idx: 10, x0: 8'd18, x4: 8'd22, x12: 8'd36, x24: 8'd54, row: 4, col: 4, fd: 1'b0};
    vecs[3] = '{idx: 15, x0: 8'd27, x4: 8'd31, x12: 8'd45, x24: 8'd63, row: 5, col: 5, fd: 1'b1};

    #1;
    pulse_reset();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] continuous ramp frame");
    start_capture();
    send_frame(0, 1'b1, 0, W * H, 1'b0);
    check_ramp_table("ramp");

    $display("[TB] ramp frame with idle gaps");
    start_capture();
    send_frame(0, 1'b1, 3, W * H, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    check_ramp_table("gaps");

    $display("[TB] back-to-back frames");
    start_capture();
    send_frame(0, 1'b1, 0, W * H, 1'b0);
    start_capture();
    send_frame(64, 1'b1, 0, W * H, 1'b0);
    compare("b2b_strobes", 256'(strobes.size()), 256'(16));
    if (strobes.size() > 0) compare("b2b_first_x24", 256'(strobes[0].x24), 256'(100));
    else compare("b2b_first_missing", 256'(strobes.size()), 256'(1));

    $display("[TB] mid-frame sof abort");
    start_capture();
    send_frame(0, 1'b1, 1, 5 * W + 3, 1'b0);
    compare("abort_frame_done", 256'(fd_count), 256'(0));
    start_capture();
    send_frame(0, 1'b1, 2, W * H, 1'b1);
    compare("abort_strobes", 256'(strobes.size()), 256'(16));
    if (strobes.size() > 0) compare("abort_first_x24", 256'(strobes[0].x24), 256'(sent[4*W+4]));
    else compare("abort_first_missing", 256'(strobes.size()), 256'(1));

    $display("[TB] reset during row 6");
    send_frame(0, 1'b1, 1, 6 * W + 3, 1'b1);
    pulse_reset();
    start_capture();
    send_frame(0, 1'b0, 0, W * H, 1'b0);
    check_ramp_table("after_reset");

    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
